// File: rtl/uart_rcv_cfg.sv
// Configurable UART receiver: synchronised RX, mid-bit sampling, optional parity,
// framing/parity error flags and overrun detection with the rdy/rdy_clr handshake.
module uart_rcv_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 rx_rdy_clr,
  output logic [DATA_BITS-1:0] cmd,
  output logic                 rx_rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_LD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  // Parity error is only meaningful when a parity bit is part of the frame.
  function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] data,
                                           input logic pbit);
    return (PARITY_EN != 0) & (^data ^ pbit ^ (PARITY_ODD != 0));
  endfunction

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic                 rx_prev_r;
  state_t               state_r;
  logic [CNT_W-1:0]     baud_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;
  logic                 stop_bit_r;
  logic                 commit_r;
  logic                 tick_s;
  logic                 fall_s;

  // Tick on counter expiry; start detection on a synchronised high-to-low step.
  always_comb begin
    tick_s = (baud_cnt_r == {CNT_W{1'b0}});
    fall_s = ~rx_sync_r & rx_prev_r;
  end

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive FSM: baud timing, bit sampling and the one-cycle commit strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      par_bit_r  <= 1'b0;
      stop_bit_r <= 1'b0;
      commit_r   <= 1'b0;
    end else begin
      commit_r <= 1'b0;
      if (!tick_s) begin
        baud_cnt_r <= baud_cnt_r - CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            baud_cnt_r <= HALF_LD;
            state_r    <= START;
          end
        end
        START: begin
          if (tick_s) begin
            if (!rx_sync_r) begin
              baud_cnt_r <= FULL_LD;
              bit_cnt_r  <= {BIT_W{1'b0}};
              state_r    <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            shift_r    <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
            baud_cnt_r <= FULL_LD;
            bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
            if (bit_cnt_r == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state_r <= PARITY;
              end else begin
                state_r <= STOP;
              end
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            par_bit_r  <= rx_sync_r;
            baud_cnt_r <= FULL_LD;
            state_r    <= STOP;
          end
        end
        STOP: begin
          if (tick_s) begin
            stop_bit_r <= rx_sync_r;
            commit_r   <= 1'b1;
            if (rx_sync_r) begin
              state_r <= IDLE;
            end else begin
              state_r <= WAIT_HI;
            end
          end
        end
        // A break holds the line low; wait for idle so it cannot look like a start bit.
        WAIT_HI: begin
          if (rx_sync_r) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output word and flags; a commit outranks a simultaneous acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd        <= {DATA_BITS{1'b0}};
      rx_rdy     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_r) begin
      cmd        <= shift_r;
      frame_err  <= ~stop_bit_r;
      parity_err <= calc_parity_err(shift_r, par_bit_r);
      rx_rdy     <= 1'b1;
      overrun    <= rx_rdy & ~rx_rdy_clr;
    end else if (rx_rdy_clr) begin
      rx_rdy  <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rcv_cfg.sv
// Directed bench for uart_rcv_cfg: default-rate instance plus two fast instances
// (8N1 and 7E1) driven from a vector table and a few hand-written sequences.
module tb_uart_rcv_cfg;

  localparam int FAST = 16;
  localparam int SLOW = 2604;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] clr = 3'b000;
  logic [7:0] cmd0;
  logic [7:0] cmd1;
  logic [6:0] cmd2;
  logic [2:0] rdy;
  logic [2:0] perr;
  logic [2:0] ferr;
  logic [2:0] ovr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0_g = 0;
  logic [2:0] rdy_q = 3'b000;
  int rise_cnt[3] = '{0, 0, 0};
  int rise_cyc[3] = '{0, 0, 0};

  uart_rcv_cfg u_dut0 (
    .clk(clk), .rst_n(rst_n), .RX(rx_line[0]), .rx_rdy_clr(clr[0]), .cmd(cmd0),
    .rx_rdy(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

  uart_rcv_cfg #(.DATA_BITS(8), .BAUD_DIV(FAST), .PARITY_EN(0), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .RX(rx_line[1]), .rx_rdy_clr(clr[1]), .cmd(cmd1),
    .rx_rdy(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

  uart_rcv_cfg #(.DATA_BITS(7), .BAUD_DIV(FAST), .PARITY_EN(1), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .RX(rx_line[2]), .rx_rdy_clr(clr[2]), .cmd(cmd2),
    .rx_rdy(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count and timestamp rising edges of each rx_rdy.
  always @(negedge clk) begin
    rdy_q <= rdy;
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] && !rdy_q[i]) begin
        rise_cnt[i] <= rise_cnt[i] + 1;
        rise_cyc[i] <= cyc;
      end
    end
  end

  typedef struct {
    int         w;
    logic [8:0] data;
    int         nbits;
    bit         pen;
    bit         pbit;
    bit         stop;
    logic [8:0] exp_cmd;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [8:0] get_cmd(input int w);
    case (w)
      0:       return {1'b0, cmd0};
      1:       return {1'b0, cmd1};
      default: return {2'b00, cmd2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input int w, input logic [8:0] data, input int nbits,
                            input bit pen, input bit pbit, input bit stop,
                            input int baud, input int hold);
    @(negedge clk);
    rx_line[w] = 1'b0;
    t0_g = cyc;
    repeat (baud) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_line[w] = data[i];
      repeat (baud) @(negedge clk);
    end
    if (pen) begin
      rx_line[w] = pbit;
      repeat (baud) @(negedge clk);
    end
    rx_line[w] = stop;
    repeat (baud) @(negedge clk);
    if (!stop) repeat (hold) @(negedge clk);
    rx_line[w] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rdy(input int w, input int budget, input string nm);
    int n = 0;
    while (!rdy[w] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, rdy[w], 1);
  endtask

  task automatic pulse_clr(input int w);
    @(negedge clk);
    clr[w] = 1'b1;
    @(negedge clk);
    clr[w] = 1'b0;
  endtask

  initial begin
    int lat;
    int n0;
    vecs[0] = '{1, 9'h0B5, 8, 1'b0, 1'b0, 1'b1, 9'h0B5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0};
    vecs[2] = '{1, 9'h081, 8, 1'b0, 1'b0, 1'b0, 9'h081, 1'b0, 1'b1};
    vecs[3] = '{1, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[4] = '{2, 9'h041, 7, 1'b1, 1'b0, 1'b1, 9'h041, 1'b0, 1'b0};
    vecs[5] = '{2, 9'h041, 7, 1'b1, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
    vecs[6] = '{2, 9'h007, 7, 1'b1, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
    vecs[7] = '{2, 9'h007, 7, 1'b1, 1'b0, 1'b1, 9'h007, 1'b1, 1'b0};
    vecs[8] = '{2, 9'h07F, 7, 1'b1, 1'b1, 1'b0, 9'h07F, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk("reset_cmd", get_cmd(w), 0);
      chk("reset_flags", {rdy[w], perr[w], ferr[w], ovr[w]}, 0);
    end

    // Default rate: 0xB5 with latency check, then a long glitch, then 0x5A.
    send_frame(0, 9'h0B5, 8, 1'b0, 1'b0, 1'b1, SLOW, 0);
    wait_rdy(0, 10, "def_rdy");
    chk("def_cmd", cmd0, 8'hB5);
    chk("def_flags", {perr[0], ferr[0], ovr[0]}, 3'b000);
    lat = 2 + SLOW / 2 + 9 * SLOW + 1;
    total++;
    if ((rise_cyc[0] - t0_g) < lat - 1 || (rise_cyc[0] - t0_g) > lat + 1) begin
      bad++;
      $display("FAIL def_latency act=%0d exp=%0d+-1", rise_cyc[0] - t0_g, lat);
    end
    pulse_clr(0);
    chk("def_clr", rdy[0], 0);

    @(negedge clk);
    n0 = rise_cnt[0];
    rx_line[0] = 1'b0;
    repeat (1000) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (2000) @(negedge clk);
    chk("glitch_rdy", rdy[0], 0);
    chk("glitch_cmd", cmd0, 8'hB5);
    chk("glitch_rise", rise_cnt[0], n0);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, SLOW, 0);
    wait_rdy(0, 10, "after_glitch_rdy");
    chk("after_glitch_cmd", cmd0, 8'h5A);
    pulse_clr(0);

    // Vector table on the fast instances.
    for (int k = 0; k < 9; k++) begin
      send_frame(vecs[k].w, vecs[k].data, vecs[k].nbits, vecs[k].pen, vecs[k].pbit,
                 vecs[k].stop, FAST, 0);
      wait_rdy(vecs[k].w, 4 * FAST, "vec_rdy");
      chk("vec_cmd", get_cmd(vecs[k].w), vecs[k].exp_cmd);
      chk("vec_perr", perr[vecs[k].w], vecs[k].exp_pe);
      chk("vec_ferr", ferr[vecs[k].w], vecs[k].exp_fe);
      chk("vec_ovr", ovr[vecs[k].w], 0);
      pulse_clr(vecs[k].w);
      chk("vec_clr", rdy[vecs[k].w], 0);
    end

    // Back-to-back frames without acknowledge.
    send_frame(1, 9'h000, 8, 1'b0, 1'b0, 1'b1, FAST, 0);
    send_frame(1, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, FAST, 0);
    chk("b2b_cmd", cmd1, 8'hFF);
    chk("b2b_rdy_ovr", {rdy[1], ovr[1]}, 2'b11);
    pulse_clr(1);
    chk("b2b_clr", {rdy[1], ovr[1]}, 2'b00);

    // Break: stop bit low and line held low for 20 bit times.
    @(negedge clk);
    n0 = rise_cnt[1];
    send_frame(1, 9'h081, 8, 1'b0, 1'b0, 1'b0, FAST, 20 * FAST);
    @(negedge clk);
    chk("break_rise", rise_cnt[1], n0 + 1);
    chk("break_ferr_ovr", {ferr[1], ovr[1]}, 2'b10);
    pulse_clr(1);
    repeat (3 * FAST) @(negedge clk);
    chk("break_idle", {rdy[1], rise_cnt[1]}, {1'b0, n0 + 1});
    send_frame(1, 9'h03C, 8, 1'b0, 1'b0, 1'b1, FAST, 0);
    wait_rdy(1, 4 * FAST, "post_break_rdy");
    chk("post_break", {cmd1, ferr[1]}, {8'h3C, 1'b0});
    pulse_clr(1);

    // Reset pulse in the middle of data bit 4; the frame must be discarded.
    @(negedge clk);
    n0 = rise_cnt[1];
    fork
      send_frame(1, 9'h0F3, 8, 1'b0, 1'b0, 1'b1, FAST, 0);
      begin
        repeat (1 + FAST + 4 * FAST + FAST / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (2 * FAST) @(negedge clk);
    chk("rst_mid_rise", rise_cnt[1], n0);
    chk("rst_mid_out1", {cmd1, rdy[1], perr[1], ferr[1], ovr[1]}, 0);
    chk("rst_mid_out0", {cmd0, rdy[0]}, 0);
    send_frame(1, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, FAST, 0);
    wait_rdy(1, 4 * FAST, "after_rst_rdy");
    chk("after_rst_cmd", cmd1, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rcv_cfg.md
Name: uart_rcv_cfg

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Width, baud divisor and parity mode are configurable. Adds an input synchroniser, start-bit glitch rejection, parity/framing error flags and overrun detection. Sits between the RX pin and the command decoder and keeps the same rdy/rdy_clr handshake.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
BAUD_DIV, 2604, clk cycles per bit, legal >= 4
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
RX  input  1  asynchronous serial line, idles high
rx_rdy_clr  input  1  consumer acknowledge, clears rx_rdy/overrun
cmd  output  DATA_BITS  last received data word
rx_rdy  output  1  new word valid in cmd
parity_err  output  1  parity mismatch on word in cmd
frame_err  output  1  stop bit sampled low on word in cmd
overrun  output  1  frame completed while rx_rdy still set

Behaviour:
- Reset (rst_n low at posedge): cmd=0, rx_rdy=0, parity_err=0, frame_err=0, overrun=0, both synchroniser flops=1, state=IDLE, counters=0.
- RX passes through a 2-flop synchroniser (rx_s). A falling edge is rx_s=0 while the previous rx_s=1.
- The baud counter counts down and "tick" fires when it reaches 0. Counter width is $clog2(BAUD_DIV).
- States:
  - IDLE: on a falling edge of rx_s, load BAUD_DIV/2-1 and go to START.
  - START: on tick, if rx_s=0, load BAUD_DIV-1, clear the bit counter and go to DATA. If rx_s=1 (glitch), return to IDLE with no flag change.
  - DATA: on each tick, shift rx_s into the MSB of a DATA_BITS shift register (LSB-first result) and reload BAUD_DIV-1. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on tick, capture the parity bit, reload, then go to STOP.
  - STOP: on tick, sample the stop bit and commit the frame (see below). If the stop bit is 1, go to IDLE; if 0 (break or framing error), go to WAIT_HI.
  - WAIT_HI: stay until rx_s=1, then go to IDLE. This prevents retriggering during a break.
- Commit, in the cycle after the stop-bit sample:
  - cmd <= shift register.
  - frame_err <= ~stop_bit.
  - parity_err <= PARITY_EN & (^data ^ parity_bit ^ PARITY_ODD).
  - rx_rdy <= 1.
  - overrun <= 1 if rx_rdy was already 1.
  - cmd is always overwritten; the newest frame wins.
- rx_rdy_clr=1 clears rx_rdy and overrun on the next edge. If the commit and rx_rdy_clr happen in the same cycle, the commit wins: rx_rdy=1, and overrun stays 0 because the clear acknowledged the old word.
- parity_err and frame_err are not cleared by rx_rdy_clr. They describe the current cmd and are updated only on commit.
- Latency: rx_rdy rises 2 + BAUD_DIV/2 + (DATA_BITS+PARITY_EN+1)*BAUD_DIV + 1 cycles (±1) after the RX falling edge.
- rst_n low mid-frame: returns to IDLE with reset values on the next edge. A partially received frame is discarded and never committed.
- rx_rdy_clr in any state never affects reception.

Test Plan:
- Defaults (8N1, BAUD_DIV=2604), serial frame 0xB5 -> cmd=8'hB5, rx_rdy=1, parity_err=0, frame_err=0 at the computed latency. Pulse rx_rdy_clr -> rx_rdy=0.
- Back-to-back frames 0x00 then 0xFF with no clear between -> cmd=8'hFF, overrun=1. Then rx_rdy_clr -> rx_rdy=0, overrun=0.
- 1000-cycle low glitch on idle RX -> START aborts, rx_rdy stays 0 and cmd is unchanged. A following frame 0x5A is received correctly.
- PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7, 0x41 with parity bit 0 -> parity_err=0. Same data with parity bit 1 -> parity_err=1, cmd=7'h41.
- Stop bit driven low, RX held low for 20 bit times -> one commit with frame_err=1 and no further rx_rdy until RX returns high and a new start bit arrives.
- rst_n low for one cycle at data bit 4 of a frame -> all outputs 0 and no rx_rdy for that frame. The next full frame 0xC3 is received correctly.
